gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__SCAN_CHAIN_RD -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd.sv | 93 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd.sv
// Scan-chain unload controller: shifts CHAIN_LEN bits out of a scan chain into DOUT,
// optionally recirculating them back into the chain head so the read is non-destructive.
module gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd #(
    parameter int CHAIN_LEN = 16,
    parameter int CW        = $clog2(CHAIN_LEN)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 RECIRC,
    input  logic                 SI,
    output logic                 SE,
    output logic                 SO,
    output logic [CHAIN_LEN-1:0] DOUT,
    output logic                 DVALID,
    input  logic                 DREADY,
    output logic                 BUSY,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        count, count_n;
    logic                 rc_q, rc_n;
    logic [CHAIN_LEN-1:0] dout_q, dout_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            count  <= '0;
            rc_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            rc_q   <= rc_n;
            dout_q <= dout_n;
        end
    end

    // Output handshake: DVALID/DOUT are held unchanged while in HOLD; a word is
    // transferred on any rising edge where DVALID=1 and DREADY=1 (DREADY is ignored otherwise).
    always_comb begin
        state_n = state;
        count_n = count;
        rc_n    = rc_q;
        dout_n  = dout_q;
        if (ABORT) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state_n = SHIFT;
                        count_n = '0;
                        rc_n    = RECIRC;
                    end
                end
                SHIFT: begin
                    dout_n = {SI, dout_q[CHAIN_LEN-1:1]};
                    if (count == CW'(CHAIN_LEN - 1)) begin
                        state_n = HOLD;
                        count_n = '0;
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
                HOLD: begin
                    if (DREADY) state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    assign SE        = (state == SHIFT);
    assign DVALID    = (state == HOLD);
    assign BUSY      = (state != IDLE);
    assign SO        = SE & rc_q & SI;
    assign DOUT      = dout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd.sv
// Bench for the scan-chain reader: a 4-bit scan chain model feeds SI and absorbs SO,
// table-driven and random transactions, plus hand sequences for hold, abort and async reset.
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd;

    localparam int L = 4;

    logic         CLK = 1'b0;
    logic         RST, START, ABORT, RECIRC, SI, DREADY;
    logic         SE, SO, DVALID, BUSY;
    logic [L-1:0] DOUT;
    logic [1:0]   state_dbg;

    int tests = 0;
    int fails = 0;

    // Chain model: bit 0 is the tail (drives SI), bit L-1 is the head (receives SO).
    logic [L-1:0] chain;
    logic         se_pre, so_pre, si_pre;

    typedef struct {
        logic [L-1:0] init;
        logic         rc;
        int           hold;
        logic         ack_start;
        logic [L-1:0] exp_dout;
        logic [L-1:0] exp_after;
    } vec_t;

    vec_t vecs[6];

    gf180mcu_fd_sc_mcu9t5v0__scan_chain_rd #(.CHAIN_LEN(L)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .RECIRC(RECIRC),
        .SI(SI), .SE(SE), .SO(SO), .DOUT(DOUT), .DVALID(DVALID),
        .DREADY(DREADY), .BUSY(BUSY), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: present the chain tail on SI, sample SE/SO before the edge,
    // then shift the chain model if the chain was enabled at that edge.
    task automatic cycle();
        SI = chain[0];
        #1;
        se_pre = SE;
        so_pre = SO;
        si_pre = SI;
        @(posedge CLK);
        if (se_pre) chain = {so_pre, chain[L-1:1]};
        #1;
    endtask

    task automatic run_txn(input logic [L-1:0] init, input logic rc, input int hold,
                           input logic ack_start, input logic [L-1:0] exp_dout,
                           input logic [L-1:0] exp_after, input string tag);
        int lat, se_cnt, so_bad;
        bit got;
        chain  = init;
        START  = 1'b1;
        RECIRC = rc;
        cycle();
        START  = 1'b0;
        RECIRC = 1'($urandom_range(0, 1));
        lat = 1; se_cnt = 0; so_bad = 0; got = 0;
        for (int i = 0; i < 3 * L; i++) begin
            if (DVALID) begin
                got = 1;
                break;
            end
            DREADY = 1'($urandom_range(0, 1));
            cycle();
            lat++;
            if (se_pre) se_cnt++;
            if (so_pre !== (rc & se_pre & si_pre)) so_bad++;
        end
        DREADY = 1'b0;
        check({tag, " dvalid"}, 32'(got), 32'd1);
        check({tag, " latency"}, lat, L + 1);
        check({tag, " se_cycles"}, se_cnt, L);
        check({tag, " so_errors"}, so_bad, 0);
        check({tag, " dout"}, 32'(DOUT), 32'(exp_dout));
        for (int i = 0; i < hold; i++) begin
            START = 1'($urandom_range(0, 1));
            cycle();
            check({tag, " hold_stable"}, {DVALID, BUSY, SE, DOUT}, {1'b1, 1'b1, 1'b0, exp_dout});
        end
        DREADY = 1'b1;
        START  = ack_start;
        cycle();
        DREADY = 1'b0;
        START  = 1'b0;
        check({tag, " ack_idle"}, {DVALID, BUSY}, 2'b00);
        cycle();
        cycle();
        check({tag, " no_relaunch"}, {SE, BUSY}, 2'b00);
        check({tag, " chain_after"}, 32'(chain), 32'(exp_after));
    endtask

    initial begin
        vecs[0] = '{4'b1101, 1'b0, 0, 1'b0, 4'b1101, 4'b0000};
        vecs[1] = '{4'b1101, 1'b1, 0, 1'b0, 4'b1101, 4'b1101};
        vecs[2] = '{4'b1101, 1'b0, 5, 1'b1, 4'b1101, 4'b0000};
        vecs[3] = '{4'b0000, 1'b1, 1, 1'b0, 4'b0000, 4'b0000};
        vecs[4] = '{4'b1111, 1'b0, 2, 1'b1, 4'b1111, 4'b0000};
        vecs[5] = '{4'b1010, 1'b1, 3, 1'b0, 4'b1010, 4'b1010};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; RECIRC = 1'b0; SI = 1'b0; DREADY = 1'b0;
        chain = '0; se_pre = 0; so_pre = 0; si_pre = 0;
        #12;
        check("reset_high", {SE, SO, DVALID, BUSY, DOUT}, 8'h00);
        @(posedge CLK);
        #1 RST = 1'b0;
        check("reset_after", {SE, SO, DVALID, BUSY, DOUT}, 8'h00);

        foreach (vecs[i])
            run_txn(vecs[i].init, vecs[i].rc, vecs[i].hold, vecs[i].ack_start,
                    vecs[i].exp_dout, vecs[i].exp_after, $sformatf("vec%0d", i));

        // Abort after two shifts: DOUT keeps the two captured bits at the top.
        #1 RST = 1'b1;
        #1 RST = 1'b0;
        chain = 4'b1101;
        START = 1'b1; RECIRC = 1'b0;
        cycle();
        START = 1'b0;
        cycle();
        cycle();
        ABORT = 1'b1;
        START = 1'b1;
        cycle();
        ABORT = 1'b0;
        START = 1'b0;
        check("abort_idle", {SE, DVALID, BUSY}, 3'b000);
        check("abort_dout", 32'(DOUT), 32'(4'b0100));
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("abort_quiet", {SE, DVALID, BUSY}, 3'b000);
        end

        // Asynchronous reset between edges in SHIFT, then a fresh transaction.
        chain = 4'b0110;
        START = 1'b1; RECIRC = 1'b1;
        cycle();
        START = 1'b0;
        cycle();
        check("pre_rst_shift", {SE, BUSY}, 2'b11);
        #2 RST = 1'b1;
        #1;
        check("async_rst", {SE, SO, BUSY, DVALID, DOUT}, 8'h00);
        #1 RST = 1'b0;
        run_txn(4'b0110, 1'b1, 1, 1'b0, 4'b0110, 4'b0110, "post_rst");

        for (int n = 0; n < 20; n++) begin
            logic [L-1:0] r_init;
            logic         r_rc;
            r_init = L'($urandom_range(0, (1 << L) - 1));
            r_rc   = 1'($urandom_range(0, 1));
            run_txn(r_init, r_rc, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                    r_init, r_rc ? r_init : '0, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
